// File: rtl/parity_frame_checker.sv
// Frame parity checker: XOR-accumulates FRAME_LEN beats of W bits, then checks one parity beat
// against the computed even/odd parity and keeps a saturating error count.
module parity_frame_checker #(
   parameter int W         = 1,
   parameter int FRAME_LEN = 8,
   parameter int ERR_CNT_W = 8,
   localparam int CW       = $clog2(FRAME_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [W-1:0]         in,
   input  logic                 in_valid,
   input  logic                 odd_mode,
   input  logic                 flush,
   output logic                 out,
   output logic                 parity_bit,
   output logic                 frame_done,
   output logic                 parity_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [CW-1:0]        beat_cnt
);

   typedef enum logic {DATA = 1'b0, CHECK = 1'b1} state_t;

   state_t               state, state_n;
   logic                 acc, acc_n;
   logic                 mode_q, mode_n;
   logic [CW-1:0]        cnt_n;
   logic [ERR_CNT_W-1:0] errc_n;
   logic                 pbit_n, done_n, perr_n;
   logic                 exp_par;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= DATA;
         acc        <= 1'b0;
         mode_q     <= 1'b0;
         beat_cnt   <= '0;
         err_count  <= '0;
         parity_bit <= 1'b0;
         frame_done <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state      <= state_n;
         acc        <= acc_n;
         mode_q     <= mode_n;
         beat_cnt   <= cnt_n;
         err_count  <= errc_n;
         parity_bit <= pbit_n;
         frame_done <= done_n;
         parity_err <= perr_n;
      end
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      mode_n  = mode_q;
      cnt_n   = beat_cnt;
      errc_n  = err_count;
      pbit_n  = parity_bit;
      done_n  = 1'b0;
      perr_n  = 1'b0;
      exp_par = acc ^ mode_q;
      // flush outranks any beat presented in the same cycle
      if (flush) begin
         state_n = DATA;
         acc_n   = 1'b0;
         cnt_n   = '0;
      end else if (in_valid) begin
         case (state)
            DATA: begin
               acc_n = acc ^ (^in);
               cnt_n = beat_cnt + CW'(1);
               if (beat_cnt == '0)
                  mode_n = odd_mode;
               if (beat_cnt == CW'(FRAME_LEN - 1))
                  state_n = CHECK;
            end
            CHECK: begin
               pbit_n  = exp_par;
               done_n  = 1'b1;
               perr_n  = (in[0] != exp_par);
               if ((in[0] != exp_par) && (err_count != '1))
                  errc_n = err_count + ERR_CNT_W'(1);
               acc_n   = 1'b0;
               cnt_n   = '0;
               state_n = DATA;
            end
            default: state_n = DATA;
         endcase
      end
   end

   assign out = acc;

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Parametrised successor to the single-bit serial parity FSM. It accumulates XOR parity over fixed-length frames of W-bit beats, with a per-frame even/odd mode. After each frame it accepts one parity beat, compares that beat against the computed parity, and reports done, error and a saturating error count. It sits on serial/parallel receive paths ahead of framing logic.

Parameters:
W, 1, data beat width in bits (>=1)
FRAME_LEN, 8, data beats per frame, excluding the parity beat (>=1)
ERR_CNT_W, 8, width of the saturating error counter (>=1)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high; clears all state
in  input  W  data beat, or the parity beat (only in[0] is used during CHECK)
in_valid  input  1  beat qualifier; no beat is consumed when low
odd_mode  input  1  0 = even parity, 1 = odd; sampled on the first data beat of each frame
flush  input  1  synchronous abort of the partial frame
out  output  1  running raw XOR of data beats accepted in the current frame (registered)
parity_bit  output  1  generated parity of the last completed frame (raw XOR ^ frame mode)
frame_done  output  1  one-cycle pulse after the parity beat is accepted
parity_err  output  1  one-cycle pulse, coincident with frame_done, on mismatch
err_count  output  ERR_CNT_W  saturating count of mismatching frames
beat_cnt  output  clog2(FRAME_LEN+1)  data beats accepted in the current frame

Behaviour:
- Reset:
  - state=DATA; acc, mode_q, beat_cnt and err_count are 0.
  - out, parity_bit, frame_done and parity_err are 0.
  - Reset has priority over flush and in_valid.
- DATA state, in_valid=1:
  - acc <= acc ^ (XOR-reduce of in); beat_cnt++.
  - If beat_cnt==0, mode_q <= odd_mode. Later changes to odd_mode within the frame are ignored.
  - On the FRAME_LEN-th beat (beat_cnt==FRAME_LEN-1 before the increment), next state is CHECK.
- CHECK state, in_valid=1:
  - exp = acc ^ mode_q.
  - Next cycle: parity_bit <= exp; frame_done <= 1; parity_err <= (in[0] != exp).
  - On mismatch, err_count++ unless it is already all-ones (saturates and holds).
  - acc and beat_cnt clear to 0; state returns to DATA.
  - in[W-1:1] is ignored.
- in_valid=0 in either state: state, acc and beat_cnt hold. frame_done and parity_err are 0.
- frame_done and parity_err are high for exactly one cycle per accepted parity beat. parity_bit holds its value until the next frame completes.
- out mirrors acc: it updates the cycle after each accepted data beat and returns to 0 the cycle after the parity beat.
- Back-to-back operation: a data beat of the next frame is accepted the cycle immediately after the parity beat, with no bubble. Throughput is FRAME_LEN+1 beats per frame.
- flush=1 (without reset):
  - acc and beat_cnt clear; state becomes DATA.
  - No frame_done, and err_count is unchanged.
  - The in_valid beat in the same cycle is discarded.
- Reset or flush mid-frame discards the partial frame. The next accepted beat is beat 0 of a new frame and re-samples odd_mode.
- FRAME_LEN=1: DATA and CHECK alternate on every accepted beat.
- State encoding is 1 bit (DATA=0, CHECK=1). Any illegal value returns to DATA.

Test Plan:
- W=1, FRAME_LEN=8, even mode, bits 1,0,1,1,0,0,0,0 then parity beat 1 -> out sequence 1,1,0,1,1,1,1,1; then frame_done=1, parity_bit=1, parity_err=0, err_count=0.
- Same data, odd mode, parity beat 1 -> parity_bit=0, parity_err=1, err_count=1. Repeat with ERR_CNT_W=2 for five bad frames -> err_count goes 1,2,3,3,3.
- W=4, FRAME_LEN=2, even mode, beats 4'hF, 4'h7, parity beat 4'hE (in[0]=0) -> exp=1, parity_err=1. Parity beat 4'h1 instead -> parity_err=0.
- Drive in_valid 1,0,0,1,... with random gaps over a FRAME_LEN=8 frame -> result identical to the gapless run. beat_cnt advances only on valid beats.
- odd_mode toggled on beat 3 of a frame -> parity uses the value sampled on beat 0. The next frame uses the new value.
- After 5 of 8 beats, assert flush (and separately reset) -> beat_cnt=0, out=0, no frame_done. A following clean frame checks correctly. Reset also clears err_count to 0; flush keeps it.
